// File: rtl/rv_isa_pkg.sv
// ---------------------------------------------------------------------------
// rv_isa_pkg
// Shared RV32I definitions used by the instruction decoder and by the
// IMEM loader / encoder.
// Contents:
//   - the seven base opcodes (OP-IMM, LOAD, OP, STORE, BRANCH, LUI, JAL)
//   - instr_class_e : field-level format class driven by the load host
//   - INSTR_NOP     : canonical NOP (addi x0,x0,0)
//   - load_state_e  : loader FSM states, also exported on state_o
// ---------------------------------------------------------------------------
package rv_isa_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      CLS_I_ALU   = 3'd0,
      CLS_LOAD    = 3'd1,
      CLS_R       = 3'd2,
      CLS_S       = 3'd3,
      CLS_B       = 3'd4,
      CLS_U       = 3'd5,
      CLS_J       = 3'd6,
      CLS_INVALID = 3'd7
   } instr_class_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2,
      ST_DONE = 2'd3
   } load_state_e;

endpackage

// File: rtl/rv_instr_encode.sv
// ---------------------------------------------------------------------------
// rv_instr_encode
// Purely combinational packer: field-level description -> RV32I word.
// Optional checking macro: RV_IMEM_LOADER_CHECK_EN
//   defined   : illegal_o flags class 7, B/J with odd offset, and B with
//               funct3 010/011.
//   undefined : illegal_o is 0; class 7 encodes the canonical NOP.
// Ports:
//   cls_i     [2:0]  format class (instr_class_e encoding)
//   rd_i, rs1_i, rs2_i [4:0] register indices
//   f3_i      [2:0]  funct3
//   f7b5_i           instruction bit 30
//   imm_i     [31:0] immediate (byte offset for B/J, full value for U)
//   word_o    [31:0] encoded instruction
//   illegal_o        description cannot be encoded (checking builds only)
// ---------------------------------------------------------------------------
module rv_instr_encode
   import rv_isa_pkg::*;
(
   input  logic [2:0]  cls_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  f3_i,
   input  logic        f7b5_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   instr_class_e cls;
   logic [6:0]   funct7;

   assign cls    = instr_class_e'(cls_i);
   assign funct7 = {1'b0, f7b5_i, 5'b0};

   always_comb begin
      word_o = INSTR_NOP;
      case (cls)
         CLS_I_ALU: begin
            word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OPC_OP_IMM};
            // Shift-immediates carry funct7 in the upper immediate bits.
            if (f3_i == 3'b001 || f3_i == 3'b101) begin
               word_o[31:25] = funct7;
            end
         end
         CLS_LOAD: word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OPC_LOAD};
         CLS_R:    word_o = {funct7, rs2_i, rs1_i, f3_i, rd_i, OPC_OP};
         CLS_S:    word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], OPC_STORE};
         CLS_B:    word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                             imm_i[4:1], imm_i[11], OPC_BRANCH};
         CLS_U:    word_o = {imm_i[31:12], rd_i, OPC_LUI};
         CLS_J:    word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                             rd_i, OPC_JAL};
         default:  word_o = INSTR_NOP;
      endcase
   end

`ifdef RV_IMEM_LOADER_CHECK_EN
   always_comb begin
      illegal_o = 1'b0;
      case (cls)
         CLS_INVALID: illegal_o = 1'b1;
         CLS_B:       illegal_o = imm_i[0] || (f3_i == 3'b010) || (f3_i == 3'b011);
         CLS_J:       illegal_o = imm_i[0];
         default:     illegal_o = 1'b0;
      endcase
   end
`else
   assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/rv_imem_loader.sv
// ---------------------------------------------------------------------------
// rv_imem_loader
// Accepts field-level instruction descriptions over a valid/ready stream,
// encodes them (rv_instr_encode) and writes them to consecutive IMEM word
// addresses starting at 0.
// Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on the FSM state (high in LOAD), never on in_valid.
// Optional checking macro: RV_IMEM_LOADER_CHECK_EN (illegal bundles are
// accepted but not written, and set sticky err until start/reset).
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   start, finish         control pulses (start has priority)
//   in_valid / in_ready   field bundle handshake
//   in_class .. in_imm    instruction fields
//   wr_en/wr_addr/wr_data registered IMEM write, one cycle after accept
//   count                 words written since start (saturates at DEPTH)
//   state_o               IDLE=0, LOAD=1, FULL=2, DONE=3
//   err                   sticky encoding error (0 without checking)
// ---------------------------------------------------------------------------
module rv_imem_loader
   import rv_isa_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_f7b5,
   input  logic [31:0]       in_imm,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W:0]   count,
   output logic [1:0]        state_o,
   output logic              err
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

   load_state_e       state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;

   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        accept;
   logic        write_ok;

   rv_instr_encode u_encode (
      .cls_i     (in_class),
      .rd_i      (in_rd),
      .rs1_i     (in_rs1),
      .rs2_i     (in_rs2),
      .f3_i      (in_funct3),
      .f7b5_i    (in_f7b5),
      .imm_i     (in_imm),
      .word_o    (enc_word),
      .illegal_o (enc_illegal)
   );

   assign in_ready = (state_q == ST_LOAD);
   assign accept   = in_valid && in_ready;
   assign write_ok = accept && !enc_illegal;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      // The write uses the pre-start count, so a start in the accept cycle
      // still lets this word land at its old address.
      if (write_ok) begin
         wr_en_d   = 1'b1;
         wr_addr_d = count_q[ADDR_W-1:0];
         wr_data_d = enc_word;
         count_d   = count_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_LOAD: begin
            if (finish) begin
               state_d = ST_DONE;
            end else if (write_ok && count_q == LAST_CNT) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: if (finish) state_d = ST_DONE;
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase

      if (start) begin
         state_d = ST_LOAD;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

`ifdef RV_IMEM_LOADER_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (accept && enc_illegal) err_d = 1'b1;
      if (start)                 err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign count   = count_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_rv_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_rv_imem_loader
// Directed bench for rv_imem_loader with DEPTH=4. Inputs change 1 time unit
// after a rising edge and outputs are checked at that same point, so every
// check observes the state registered by the preceding edge.
// ---------------------------------------------------------------------------
module tb_rv_imem_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_f7b5;
  logic [31:0]       in_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;
  logic [1:0]        state_o;
  logic              err;

  int vectors    = 0;
  int miscompares = 0;

  rv_imem_loader #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .finish    (finish),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_f7b5   (in_f7b5),
    .in_imm    (in_imm),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .count     (count),
    .state_o   (state_o),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- checks --------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, ".wr_en"},   32'(wr_en),   32'd1);
    chk({tag, ".wr_addr"}, 32'(wr_addr), addr);
    chk({tag, ".wr_data"}, wr_data,      data);
  endtask

  // ---- drivers -------------------------------------------------------------
  task automatic set_fields(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                            input logic [31:0] imm);
    in_class  = cls;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_f7b5   = f7b5;
    in_imm    = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one-cycle valid pulse; caller checks the write that follows
  task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                      input logic [31:0] imm);
    set_fields(cls, rd, rs1, rs2, f3, f7b5, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  // back-to-back table: lui, srai, addi, add, sub (fifth must be refused)
  logic [2:0]  v_cls [5];
  logic [4:0]  v_rd  [5];
  logic [4:0]  v_rs1 [5];
  logic [4:0]  v_rs2 [5];
  logic [2:0]  v_f3  [5];
  logic        v_f7  [5];
  logic [31:0] v_imm [5];
  logic [31:0] v_exp [4];

  initial begin
    v_cls[0] = 3'd5; v_rd[0] = 5'd4; v_rs1[0] = 5'd0; v_rs2[0] = 5'd0; v_f3[0] = 3'd0; v_f7[0] = 1'b0; v_imm[0] = 32'h1234_5000;
    v_cls[1] = 3'd0; v_rd[1] = 5'd6; v_rs1[1] = 5'd7; v_rs2[1] = 5'd0; v_f3[1] = 3'd5; v_f7[1] = 1'b1; v_imm[1] = 32'd3;
    v_cls[2] = 3'd0; v_rd[2] = 5'd1; v_rs1[2] = 5'd0; v_rs2[2] = 5'd0; v_f3[2] = 3'd0; v_f7[2] = 1'b0; v_imm[2] = 32'hFFFF_FFFF;
    v_cls[3] = 3'd2; v_rd[3] = 5'd3; v_rs1[3] = 5'd1; v_rs2[3] = 5'd2; v_f3[3] = 3'd0; v_f7[3] = 1'b0; v_imm[3] = 32'd0;
    v_cls[4] = 3'd2; v_rd[4] = 5'd3; v_rs1[4] = 5'd1; v_rs2[4] = 5'd2; v_f3[4] = 3'd0; v_f7[4] = 1'b1; v_imm[4] = 32'd0;
    v_exp[0] = 32'h1234_5237;
    v_exp[1] = 32'h4033_D313;
    v_exp[2] = 32'hFFF0_0093;
    v_exp[3] = 32'h0020_81B3;
  end

  // ---- directed sequence ---------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    in_valid = 1'b0;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    step();
    step();

    // reset values
    chk("rst.state",    32'(state_o),  32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.wr_en",    32'(wr_en),    32'd0);
    chk("rst.wr_addr",  32'(wr_addr),  32'd0);
    chk("rst.wr_data",  wr_data,       32'd0);
    chk("rst.count",    32'(count),    32'd0);
    chk("rst.err",      32'(err),      32'd0);
    rst_n = 1'b1;
    step();
    chk("idle.in_ready", 32'(in_ready), 32'd0);

    // add / sub
    pulse_start();
    chk("start.state",    32'(state_o),  32'd1);
    chk("start.in_ready", 32'(in_ready), 32'd1);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    chk_wr("add", 32'd0, 32'h0020_81B3);
    chk("add.count", 32'(count), 32'd1);
    step();
    chk("pulse.wr_en", 32'(wr_en), 32'd0);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
    chk_wr("sub", 32'd1, 32'h4020_81B3);
    chk("sub.count", 32'(count), 32'd2);
    pulse_finish();
    chk("fin.state",    32'(state_o),  32'd3);
    chk("fin.in_ready", 32'(in_ready), 32'd0);
    chk("fin.count",    32'(count),    32'd2);

    // lw, jal, beq, sw
    pulse_start();
    chk("restart.count", 32'(count), 32'd0);
    send(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd8);
    chk_wr("lw", 32'd0, 32'h0081_2283);
    send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
    chk_wr("jal", 32'd1, 32'h0080_00EF);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);
    chk_wr("beq", 32'd2, 32'hFE20_8EE3);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd12);
    chk_wr("sw", 32'd3, 32'h0020_A623);
    chk("sw.state", 32'(state_o), 32'd2);

    // five back-to-back valids into a 4-word memory
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_fields(v_cls[i], v_rd[i], v_rs1[i], v_rs2[i], v_f3[i], v_f7[i], v_imm[i]);
      step();
      if (i < 4) begin
        chk_wr($sformatf("b2b%0d", i), 32'(i), v_exp[i]);
      end else begin
        chk("b2b4.wr_en", 32'(wr_en), 32'd0);
      end
      if (i == 3) begin
        chk("full.state",    32'(state_o),  32'd2);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        chk("full.count",    32'(count),    32'd4);
      end
    end
    in_valid = 1'b0;
    chk("sat.count", 32'(count), 32'd4);
    pulse_finish();
    chk("full_fin.state", 32'(state_o), 32'd3);
    chk("full_fin.count", 32'(count),   32'd4);

    // accept together with finish
    pulse_start();
    finish = 1'b1;
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    finish = 1'b0;
    chk_wr("accfin", 32'd0, 32'h0020_81B3);
    chk("accfin.state", 32'(state_o), 32'd3);
    chk("accfin.count", 32'(count),   32'd1);

    // start together with accept: old address, counter restarts
    pulse_start();
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    chk_wr("pre", 32'd0, 32'h0020_81B3);
    start = 1'b1;
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
    start = 1'b0;
    chk_wr("stacc", 32'd1, 32'h4020_81B3);
    chk("stacc.count", 32'(count),   32'd0);
    chk("stacc.state", 32'(state_o), 32'd1);
    send(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd8);
    chk_wr("post", 32'd0, 32'h0081_2283);

`ifdef RV_IMEM_LOADER_CHECK_EN
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3);
    chk("bodd.wr_en", 32'(wr_en), 32'd0);
    chk("bodd.err",   32'(err),   32'd1);
    chk("bodd.count", 32'(count), 32'd1);
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    chk("cls7.wr_en", 32'(wr_en), 32'd0);
    chk("cls7.err",   32'(err),   32'd1);
    pulse_start();
    chk("errclr.err", 32'(err), 32'd0);
`else
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    chk_wr("cls7", 32'd1, 32'h0000_0013);
    chk("cls7.err",   32'(err),   32'd0);
    chk("cls7.count", 32'(count), 32'd2);
    pulse_start();
`endif

    // asynchronous reset mid-stream
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    chk_wr("prerst", 32'd0, 32'h0020_81B3);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.wr_en",    32'(wr_en),    32'd0);
    chk("arst.wr_addr",  32'(wr_addr),  32'd0);
    chk("arst.wr_data",  wr_data,       32'd0);
    chk("arst.count",    32'(count),    32'd0);
    chk("arst.state",    32'(state_o),  32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    step();
    chk("arst_hold.wr_en", 32'(wr_en), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("arst_rel.wr_en", 32'(wr_en),   32'd0);
    chk("arst_rel.state", 32'(state_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_imem_loader.md
# rv_imem_loader

Encoding-side counterpart to the core's instruction decoder. Accepts field-level instruction descriptions (format class, registers, funct3, immediate) over a valid/ready stream, packs them into RV32I instruction words using the decoder's opcode map, and writes them sequentially into instruction memory. Sits between the test/boot host and the IMEM write port.

## Interface
- DEPTH, 256: IMEM depth in words; legal range 2..65536.
- ADDR_W, $clog2(DEPTH): word-address width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  pulse: clear counter and error, enter LOAD.
- finish  in  1  pulse: end load, enter DONE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept.
- in_class  in  3  0=I-alu, 1=L, 2=R, 3=S, 4=B, 5=U(lui), 6=J(jal), 7=invalid.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3.
- in_f7b5  in  1  instruction bit 30 (sub/sra/srai).
- in_imm  in  32  immediate, byte offset for B/J, full value for U (bits 31:12 used).
- wr_en  out  1  IMEM write strobe.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since start.
- state_o  out  2  IDLE=0, LOAD=1, FULL=2, DONE=3.
- err  out  1  sticky error (see Configuration).

## Operation
- IDLE -> LOAD on start. LOAD -> FULL when the DEPTH-th word is accepted. LOAD -> DONE on finish. FULL -> DONE on finish. Any state -> LOAD on start (counter, address, err cleared).
- in_ready = (state_o==LOAD). Accept = in_valid && in_ready.
- Encoding (opcode[6:0] = 0010011, 0000011, 0110011, 0100011, 1100011, 0110111, 1101111 for classes 0..6):
  - R: {1'b0,f7b5,5'b0, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}; if f3 is 001/101, bits 31:25 = {1'b0,f7b5,5'b0}.
  - L: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Unused imm bits ignored; no range check on truncation.
- Address wraps never: FULL blocks further input; count saturates at DEPTH.
- Simultaneous accept + finish: word accepted and written, then DONE.
- start while a write is in flight: in-flight write completes at its old address; counter restarts at 0 after it.
- Reset mid-load: in-flight write dropped, all state cleared.

## Timing
- Reset values: state_o=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, err=0.
- Latency 1: accept in cycle N -> wr_en=1 with wr_addr/wr_data registered in N+1; count increments in N+1.
- Throughput one word per cycle; wr_en is a single-cycle pulse per word.
- state_o reaches FULL in the cycle after the DEPTH-th accept (same edge as its write).

## Configuration
- RV_IMEM_LOADER_CHECK_EN defined: class 7, B/J with imm[0]=1, and B with f3 in {010,011} are rejected; word accepted (handshake completes) but not written, counter unchanged, err set until start or reset.
- Undefined: no checks; class 7 encodes NOP 0x00000013 and is written normally; err tied 0.

## Structure
- Shared package rv_isa_pkg: the seven opcode constants (also used by the decoder), class enum, NOP constant, state enum.
- Sub-module rv_instr_encode: purely combinational fields -> 32-bit word (+ illegal flag); loader holds the FSM, counter and output register.

## Test plan
- R add x3,x1,x2 then sub (f7b5=1) -> wr_addr 0/1, wr_data 0x002081B3 then 0x402081B3, one cycle after each accept.
- L lw x5,8(x2) -> 0x00812283; J jal x1,+8 -> 0x008000EF.
- B beq x1,x2,imm=-4 -> 0xFE208EE3 (sign bits placed correctly).
- DEPTH=4, five back-to-back valids -> four writes at 0..3, in_ready low after fourth accept, state_o=FULL, count=4; finish -> DONE.
- With RV_IMEM_LOADER_CHECK_EN: beq imm=3 -> no wr_en, err=1, count unchanged; start -> err=0. Without: class 7 -> writes 0x00000013.
- rst_n asserted during streaming -> outputs to reset values asynchronously; pending write never appears.
